// File: rtl/ikascc_bus_sync.sv
// ikascc_bus_sync: turns the asynchronous cartridge-bus strobes into
// one-ce-period read/write requests on the emulator clock. The strobes are
// synchronized, filtered for glitches, and each accepted access latches its
// address and data for the core.
module ikascc_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_TICKS  = 2
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_MCLK_PCEN_n,
  input  logic        i_CS_n,
  input  logic        i_WR_n,
  input  logic        i_RD_n,
  input  logic [15:0] i_AB,
  input  logic [7:0]  i_DB,
  output logic        o_WRRQ,
  output logic        o_RDRQ,
  output logic [4:0]  o_ABHI,
  output logic [7:0]  o_ABLO,
  output logic [7:0]  o_DB,
  output logic        o_BUSY
);

  typedef enum logic [2:0] {
    ST_ARM  = 3'd0,
    ST_IDLE = 3'd1,
    ST_FILT = 3'd2,
    ST_WREQ = 3'd3,
    ST_RREQ = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  localparam logic [2:0] SYNC_CNT = 3'(SYNC_STAGES);
  localparam logic [2:0] FILT_CNT = 3'(FILT_TICKS);

  logic                   ce_s;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] wr_sync_r;
  logic [SYNC_STAGES-1:0] rd_sync_r;
  logic                   cs_s;
  logic                   wr_s;
  logic                   rd_s;
  logic                   wr_act_s;
  logic                   rd_act_s;
  logic                   rec_act_s;
  logic                   rec_hi_s;
  state_t                 state_r;
  state_t                 state_nx_s;
  logic [2:0]             cnt_r;
  logic [2:0]             cnt_nx_s;
  logic                   is_wr_r;
  logic                   is_wr_nx_s;
  logic [4:0]             abhi_cap_r;
  logic [7:0]             ablo_cap_r;
  logic [7:0]             db_cap_r;
  logic                   wrrq_r;
  logic                   rdrq_r;
  logic                   busy_r;
  logic [4:0]             abhi_r;
  logic [7:0]             ablo_r;
  logic [7:0]             db_r;
  logic                   unused_ab_s;

  // i_AB[10:8] is not part of the decoded address window
  assign unused_ab_s = ^i_AB[10:8];

  assign ce_s = ~i_MCLK_PCEN_n;
  assign cs_s = cs_sync_r[SYNC_STAGES-1];
  assign wr_s = wr_sync_r[SYNC_STAGES-1];
  assign rd_s = rd_sync_r[SYNC_STAGES-1];

  // write wins when both strobes are low
  assign wr_act_s  = ~cs_s & ~wr_s;
  assign rd_act_s  = ~cs_s & ~rd_s & ~wr_act_s;
  assign rec_act_s = is_wr_r ? wr_act_s : rd_act_s;
  assign rec_hi_s  = cs_s | (is_wr_r ? wr_s : rd_s);

  // Strobe synchronizer chains, advanced on ce ticks, parked high in reset
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      cs_sync_r <= {SYNC_STAGES{1'b1}};
      wr_sync_r <= {SYNC_STAGES{1'b1}};
      rd_sync_r <= {SYNC_STAGES{1'b1}};
    end else if (ce_s) begin
      cs_sync_r <= {cs_sync_r[SYNC_STAGES-2:0], i_CS_n};
      wr_sync_r <= {wr_sync_r[SYNC_STAGES-2:0], i_WR_n};
      rd_sync_r <= {rd_sync_r[SYNC_STAGES-2:0], i_RD_n};
    end
  end

  // Next-state logic; in ARM the counter first flushes the reset value out of
  // the synchronizers so a strobe held low across reset is really seen
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    is_wr_nx_s = is_wr_r;
    case (state_r)
      ST_ARM: begin
        if (cnt_r < SYNC_CNT) begin
          cnt_nx_s = cnt_r + 3'd1;
        end else if (cs_s & wr_s & rd_s) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 3'd0;
        end else begin
          state_nx_s = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (wr_act_s) begin
          state_nx_s = ST_FILT;
          cnt_nx_s   = 3'd1;
          is_wr_nx_s = 1'b1;
        end else if (rd_act_s) begin
          state_nx_s = ST_FILT;
          cnt_nx_s   = 3'd1;
          is_wr_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FILT: begin
        if (rec_act_s) begin
          if (cnt_r == FILT_CNT) begin
            state_nx_s = is_wr_r ? ST_WREQ : ST_RREQ;
            cnt_nx_s   = 3'd0;
          end else begin
            cnt_nx_s = cnt_r + 3'd1;
          end
        end else if (!is_wr_r && wr_act_s) begin
          // a read turning into a write restarts the filter as a write
          cnt_nx_s   = 3'd1;
          is_wr_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 3'd0;
        end
      end
      ST_WREQ: begin
        state_nx_s = ST_HOLD;
      end
      ST_RREQ: begin
        state_nx_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (rec_hi_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_ARM;
        cnt_nx_s   = 3'd0;
      end
    endcase
  end

  // FSM state, filter counter and recorded access type
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state_r <= ST_ARM;
      cnt_r   <= 3'd0;
      is_wr_r <= 1'b0;
    end else if (ce_s) begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      is_wr_r <= is_wr_nx_s;
    end
  end

  // Address/data capture while waiting for or filtering a strobe
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      abhi_cap_r <= 5'd0;
      ablo_cap_r <= 8'd0;
      db_cap_r   <= 8'd0;
    end else if (ce_s && ((state_r == ST_IDLE) || (state_r == ST_FILT))) begin
      abhi_cap_r <= i_AB[15:11];
      ablo_cap_r <= i_AB[7:0];
      db_cap_r   <= i_DB;
    end
  end

  // Registered outputs decoded from the next state so they track the FSM exactly
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wrrq_r <= 1'b0;
      rdrq_r <= 1'b0;
      busy_r <= 1'b0;
      abhi_r <= 5'd0;
      ablo_r <= 8'd0;
      db_r   <= 8'd0;
    end else if (ce_s) begin
      wrrq_r <= (state_nx_s == ST_WREQ);
      rdrq_r <= (state_nx_s == ST_RREQ);
      busy_r <= (state_nx_s != ST_IDLE);
      if ((state_r == ST_FILT) &&
          ((state_nx_s == ST_WREQ) || (state_nx_s == ST_RREQ))) begin
        abhi_r <= abhi_cap_r;
        ablo_r <= ablo_cap_r;
        db_r   <= db_cap_r;
      end
    end
  end

  assign o_WRRQ = wrrq_r;
  assign o_RDRQ = rdrq_r;
  assign o_BUSY = busy_r;
  assign o_ABHI = abhi_r;
  assign o_ABLO = ablo_r;
  assign o_DB   = db_r;

endmodule

// File: tb/tb_ikascc_bus_sync.sv
// Bench for ikascc_bus_sync: strobe episodes aligned to ce ticks, with a
// transaction-level model predicting, per ce tick, the request pulse, busy
// window and latched address/data.
module tb_ikascc_bus_sync;

  localparam int S    = 2;
  localparam int F    = 2;
  localparam int MAXK = 2048;

  logic        emuclk = 1'b0;
  logic        rst    = 1'b1;
  logic        pcen_n;
  logic        cs_n   = 1'b1;
  logic        wr_n   = 1'b1;
  logic        rd_n   = 1'b1;
  logic [15:0] ab     = 16'h0000;
  logic [7:0]  db     = 8'h00;
  logic        wrrq;
  logic        rdrq;
  logic [4:0]  abhi;
  logic [7:0]  ablo;
  logic [7:0]  dbo;
  logic        busy;

  logic [1:0]  ce_cnt = 2'd0;
  int          cur_k  = -1;

  bit          exp_wr   [MAXK];
  bit          exp_rd   [MAXK];
  bit          exp_busy [MAXK];
  logic [15:0] exp_ab   [MAXK];
  logic [7:0]  exp_db   [MAXK];

  int    errors  = 0;
  int    checks  = 0;
  int    wr_cyc  = 0;
  int    rd_cyc  = 0;
  int    pin_seq = 0;
  int    pin_seen = 0;
  string pin_name = "";
  int    pin_act = 0;
  int    pin_exp = 0;

  ikascc_bus_sync #(.SYNC_STAGES(S), .FILT_TICKS(F)) dut (
    .i_EMUCLK     (emuclk),
    .i_RST        (rst),
    .i_MCLK_PCEN_n(pcen_n),
    .i_CS_n       (cs_n),
    .i_WR_n       (wr_n),
    .i_RD_n       (rd_n),
    .i_AB         (ab),
    .i_DB         (db),
    .o_WRRQ       (wrrq),
    .o_RDRQ       (rdrq),
    .o_ABHI       (abhi),
    .o_ABLO       (ablo),
    .o_DB         (dbo),
    .o_BUSY       (busy)
  );

  always #5 emuclk = ~emuclk;

  // ce tick on one rising edge out of every four
  always @(negedge emuclk) ce_cnt <= ce_cnt + 2'd1;
  assign pcen_n = (ce_cnt != 2'd0);

  // ce tick index since the last reset release
  always @(posedge emuclk or posedge rst) begin
    if (rst) cur_k <= -1;
    else if (!pcen_n) cur_k <= cur_k + 1;
  end

  // request-cycle counters
  always @(negedge emuclk) begin
    if (wrrq) wr_cyc <= wr_cyc + 1;
    if (rdrq) rd_cyc <= rd_cyc + 1;
  end

  // compare process: posted literal checks plus per-cycle model comparison
  always @(negedge emuclk) begin : cmp
    int add_c;
    int add_e;
    logic [23:0] act_v;
    logic [23:0] exp_v;
    add_c = 0;
    add_e = 0;
    if (pin_seq != pin_seen) begin
      add_c = add_c + 1;
      if (pin_act != pin_exp) begin
        add_e = add_e + 1;
        $display("FAIL %s: got %0d expected %0d", pin_name, pin_act, pin_exp);
      end
    end
    pin_seen <= pin_seq;
    if (!rst) begin
      add_c = add_c + 1;
      act_v = {wrrq, rdrq, busy, abhi, ablo, dbo};
      if (cur_k >= MAXK) begin
        add_e = add_e + 1;
        $display("FAIL tick_range: got tick %0d expected below %0d", cur_k, MAXK);
      end else begin
        if (cur_k < 0) exp_v = 24'd0;
        else exp_v = {exp_wr[cur_k], exp_rd[cur_k], exp_busy[cur_k],
                      exp_ab[cur_k][15:11], exp_ab[cur_k][7:0], exp_db[cur_k]};
        if (act_v !== exp_v) begin
          add_e = add_e + 1;
          $display("FAIL outputs@tick%0d: got wr=%b rd=%b busy=%b abhi=%b ablo=%h db=%h expected wr=%b rd=%b busy=%b abhi=%b ablo=%h db=%h",
                   cur_k, act_v[23], act_v[22], act_v[21], act_v[20:16], act_v[15:8], act_v[7:0],
                   exp_v[23], exp_v[22], exp_v[21], exp_v[20:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
    checks <= checks + add_c;
    errors <= errors + add_e;
  end

  // post one literal comparison to the compare process
  task automatic pin(input string name, input int act, input int expv);
    pin_name = name;
    pin_act  = act;
    pin_exp  = expv;
    pin_seq  = pin_seq + 1;
    @(negedge emuclk);
    #1;
  endtask

  // return just after the next ce tick
  task automatic wait_tick();
    @(posedge emuclk);
    while (pcen_n) @(posedge emuclk);
    #1;
  endtask

  // after reset: outputs zero, busy until strobes are seen high (pins high
  // from tick h onward) once the synchronizers have been refilled
  task automatic model_reset(input int h);
    for (int k = 0; k < MAXK; k++) begin
      exp_wr[k]   = 1'b0;
      exp_rd[k]   = 1'b0;
      exp_busy[k] = (k < h + S);
      exp_ab[k]   = 16'h0000;
      exp_db[k]   = 8'h00;
    end
  endtask

  // strobe low for ticks t0..t0+L-1: the core sees it S ticks later; it is
  // accepted if it lasts at least F+1 ticks and the request appears after tick
  // t0+S+F; busy lasts L ticks, but never less than F+2 when accepted
  task automatic model_episode(input int kind, input int t0, input int L,
                               input logic [15:0] a, input logic [7:0] d);
    int span;
    int r;
    bit req;
    req  = (L >= F + 1);
    span = L;
    if (req && span < F + 2) span = F + 2;
    for (int k = t0 + S; k < t0 + S + span; k++)
      if (k < MAXK) exp_busy[k] = 1'b1;
    if (req) begin
      r = t0 + S + F;
      if (r < MAXK) begin
        if (kind == 1) exp_rd[r] = 1'b1;
        else exp_wr[r] = 1'b1;
        for (int k = r; k < MAXK; k++) begin
          exp_ab[k] = a;
          exp_db[k] = d;
        end
      end
    end
  endtask

  // kind: 0 write, 1 read, 2 both strobes low; gap = high ticks afterwards
  task automatic run_episode(input int kind, input logic [15:0] a, input logic [7:0] d,
                             input int L, input int gap);
    model_episode(kind, cur_k + 1, L, a, d);
    ab   = a;
    db   = d;
    cs_n = 1'b0;
    wr_n = (kind == 1);
    rd_n = (kind == 0);
    repeat (L) wait_tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
    if (gap > S + F + 2) begin
      repeat (S + F + 2) wait_tick();
      ab = 16'($urandom);
      db = 8'($urandom);
      repeat (gap - S - F - 2) wait_tick();
    end else begin
      repeat (gap) wait_tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    int kind;
    int len;
    int gap;
    bit found;
    int snap;

    model_reset(0);
    rst = 1'b1;
    repeat (3) @(negedge emuclk);
    #1;
    pin("reset_outputs", int'({wrrq, rdrq, busy, abhi, ablo, dbo}), 0);
    rst = 1'b0;
    repeat (4) wait_tick();

    // long write at 0x9000
    w0 = wr_cyc;
    r0 = rd_cyc;
    run_episode(0, 16'h9000, 8'h3F, 10, 8);
    pin("long_write_wrrq_cycles", wr_cyc - w0, 4);
    pin("long_write_rdrq_cycles", rd_cyc - r0, 0);
    pin("long_write_abhi", int'(abhi), 18);
    pin("long_write_ablo", int'(ablo), 0);
    pin("long_write_db", int'(dbo), 63);

    // one-tick write glitch
    w0 = wr_cyc;
    run_episode(0, 16'h1234, 8'hAA, 1, 8);
    pin("glitch_wrrq_cycles", wr_cyc - w0, 0);
    pin("glitch_busy", int'(busy), 0);
    pin("glitch_abhi_held", int'(abhi), 18);

    // both strobes low: write wins
    w0 = wr_cyc;
    r0 = rd_cyc;
    run_episode(2, 16'h5000, 8'h77, 6, 8);
    pin("both_wrrq_cycles", wr_cyc - w0, 4);
    pin("both_rdrq_cycles", rd_cyc - r0, 0);
    pin("both_abhi", int'(abhi), 10);

    // reset released with the write strobe low
    rst  = 1'b1;
    cs_n = 1'b0;
    wr_n = 1'b0;
    #3;
    model_reset(5);
    @(negedge emuclk);
    rst = 1'b0;
    w0 = wr_cyc;
    repeat (5) wait_tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
    repeat (8) wait_tick();
    pin("armed_no_request", wr_cyc - w0, 0);
    w0 = wr_cyc;
    run_episode(0, 16'hC123, 8'h5A, 6, 8);
    pin("armed_then_write", wr_cyc - w0, 4);

    // reset pulse while the write request is up
    model_episode(0, cur_k + 1, 40, 16'hA5A5, 8'hC3);
    ab    = 16'hA5A5;
    db    = 8'hC3;
    cs_n  = 1'b0;
    wr_n  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_tick();
      if (wrrq) found = 1'b1;
    end
    pin("abort_wrrq_seen", int'(found), 1);
    if (found) begin
      @(posedge emuclk);
      while (pcen_n) @(posedge emuclk);
    end
    #2;
    rst = 1'b1;
    #1;
    snap = int'({wrrq, busy});
    pin("abort_async_drop", snap, 0);
    model_reset(4);
    @(negedge emuclk);
    rst = 1'b0;
    w0 = wr_cyc;
    repeat (4) wait_tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
    repeat (12) wait_tick();
    pin("abort_no_reissue", wr_cyc - w0, 0);

    // back-to-back reads
    r0 = rd_cyc;
    run_episode(1, 16'h9800, 8'h00, 6, 1);
    pin("read1_abhi", int'(abhi), 19);
    run_episode(1, 16'hB000, 8'h00, 6, 8);
    pin("read2_abhi", int'(abhi), 22);
    pin("reads_rdrq_cycles", rd_cyc - r0, 8);

    // randomized episodes
    repeat (40) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 12));
      gap  = S + F + 2 + int'($urandom_range(1, 3));
      run_episode(kind, 16'($urandom), 8'($urandom), len, gap);
    end

    repeat (4) @(negedge emuclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
